// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the PC / fetch-address stage.
//   pc_state_e : fetch FSM state (RUN, HALT)
//   pc_sel_e   : next-PC source chosen by pc_target (SEQ, BRANCH, JAL, JALR)
//   PC_INC     : sequential PC increment
//   pc_aligned : true when an address is 4-byte aligned
package pc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_e;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JAL    = 2'd2,
    JALR   = 2'd3
  } pc_sel_e;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic pc_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: signals between the decode/execute side and the PC stage.
//   Controls (driven by master): i_immediate, i_rs1_rdata, i_branch,
//     i_branch_taken, i_jal, i_jalr, i_stall.
//   Results (driven by slave = pc_fetch): o_imem_raddr, o_pc, o_pc_plus4,
//     o_retire, o_instret, o_trap, o_trap_addr.
// Handshake: there is no valid/ready pair. The controls describe the
// instruction at o_pc and are sampled on every rising clock edge; i_stall
// is the only flow control and, when high, that edge makes no progress.
interface pc_fetch_if;
  logic [31:0] i_immediate;
  logic [31:0] i_rs1_rdata;
  logic        i_branch;
  logic        i_branch_taken;
  logic        i_jal;
  logic        i_jalr;
  logic        i_stall;
  logic [31:0] o_imem_raddr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_retire;
  logic [63:0] o_instret;
  logic        o_trap;
  logic [31:0] o_trap_addr;

  modport master (
    output i_immediate, i_rs1_rdata, i_branch, i_branch_taken,
           i_jal, i_jalr, i_stall,
    input  o_imem_raddr, o_pc, o_pc_plus4, o_retire, o_instret,
           o_trap, o_trap_addr
  );

  modport slave (
    input  i_immediate, i_rs1_rdata, i_branch, i_branch_taken,
           i_jal, i_jalr, i_stall,
    output o_imem_raddr, o_pc, o_pc_plus4, o_retire, o_instret,
           o_trap, o_trap_addr
  );
endinterface

// File: rtl/pc_target.sv
// pc_target: combinational next-PC target selection.
//   pc, immediate, rs1_rdata      : operands
//   branch, branch_taken, jal, jalr: decoder controls
//   target                        : selected next PC (not yet alignment-checked)
//   sel                           : which source was selected
// Priority when several controls are set: jalr > jal > taken branch > sequential.
module pc_target
  import pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] immediate,
  input  logic [31:0] rs1_rdata,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  output logic [31:0] target,
  output pc_sel_e     sel
);

  logic [31:0] rel_target;
  logic [31:0] jalr_sum;

  // Carries out of bit 31 are dropped: addresses wrap at 2^32.
  assign rel_target = pc + immediate;
  assign jalr_sum   = rs1_rdata + immediate;

  always_comb begin
    target = pc + PC_INC;
    sel    = SEQ;
    if (jalr) begin
      target = {jalr_sum[31:1], 1'b0};
      sel    = JALR;
    end else if (jal) begin
      target = rel_target;
      sel    = JAL;
    end else if (branch && branch_taken) begin
      target = rel_target;
      sel    = BRANCH;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch address stage.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : pc_fetch_if.slave (controls in, PC / retire / trap out)
//   o_state      : current FSM state (debug visibility)
//   o_sel        : next-PC source selected this cycle (debug visibility)
// Parameter RESET_ADDR: PC after reset, must be 4-byte aligned.
// Macro PC_MISALIGN_TRAP_EN: when defined, a misaligned non-sequential
// target traps into HALT; when undefined, target bits [1:0] are cleared
// and every non-stalled cycle retires.
module pc_fetch
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  pc_fetch_if.slave   bus,
  output pc_state_e   o_state,
  output pc_sel_e     o_sel
);

  pc_state_e   state_q;
  logic [31:0] pc_q;
  logic        retire_q;
  logic [63:0] instret_q;
  logic [31:0] target;
  pc_sel_e     sel;

  pc_target u_target (
    .pc           (pc_q),
    .immediate    (bus.i_immediate),
    .rs1_rdata    (bus.i_rs1_rdata),
    .branch       (bus.i_branch),
    .branch_taken (bus.i_branch_taken),
    .jal          (bus.i_jal),
    .jalr         (bus.i_jalr),
    .target       (target),
    .sel          (sel)
  );

`ifdef PC_MISALIGN_TRAP_EN
  logic        trap_q;
  logic [31:0] trap_addr_q;
  logic        misaligned;

  // Sequential targets stay aligned because the PC always is.
  assign misaligned = (sel != SEQ) && !pc_aligned(target);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_ADDR;
      retire_q    <= 1'b0;
      instret_q   <= 64'd0;
      trap_q      <= 1'b0;
      trap_addr_q <= 32'd0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (!bus.i_stall) begin
            if (misaligned) begin
              state_q     <= HALT;
              trap_q      <= 1'b1;
              trap_addr_q <= target;
            end else begin
              pc_q      <= target;
              retire_q  <= 1'b1;
              instret_q <= instret_q + 64'd1;
            end
          end
        end
        HALT: begin
          // Everything frozen until reset.
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.o_trap      = trap_q;
  assign bus.o_trap_addr = trap_addr_q;
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_ADDR;
      retire_q  <= 1'b0;
      instret_q <= 64'd0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (!bus.i_stall) begin
            // Low bits dropped so the PC can never become misaligned.
            pc_q      <= target & ~32'h3;
            retire_q  <= 1'b1;
            instret_q <= instret_q + 64'd1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.o_trap      = 1'b0;
  assign bus.o_trap_addr = 32'd0;
`endif

  assign bus.o_pc         = pc_q;
  assign bus.o_imem_raddr = pc_q;
  assign bus.o_pc_plus4   = pc_q + PC_INC;
  assign bus.o_retire     = retire_q;
  assign bus.o_instret    = instret_q;
  assign o_state          = state_q;
  assign o_sel            = sel;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch with a reference model of the
// architectural PC state and a per-cycle comparison against it.
module tb_pc_fetch;
  import pc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_if bus ();
  pc_state_e  dbg_state;
  pc_sel_e    dbg_sel;

  pc_fetch #(.RESET_ADDR(32'h0000_0000)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .bus     (bus),
    .o_state (dbg_state),
    .o_sel   (dbg_sel)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [63:0] m_instret;
  logic        m_retire;
  logic        m_trap;
  logic [31:0] m_trap_addr;
  logic        m_halt;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    logic [31:0] t;
    logic        jump;
    if (rst) begin
      m_valid = 1'b1; m_pc = 32'h0; m_instret = 64'd0; m_retire = 1'b0;
      m_trap = 1'b0; m_trap_addr = 32'h0; m_halt = 1'b0;
    end else if (m_halt || bus.i_stall) begin
      m_retire = 1'b0;
    end else begin
      jump = bus.i_jalr || bus.i_jal || (bus.i_branch && bus.i_branch_taken);
      if (bus.i_jalr)      t = (bus.i_rs1_rdata + bus.i_immediate) & ~32'h1;
      else if (jump)       t = m_pc + bus.i_immediate;
      else                 t = m_pc + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
      if (jump && (t % 4 != 0)) begin
        m_halt = 1'b1; m_trap = 1'b1; m_trap_addr = t; m_retire = 1'b0;
      end else begin
        m_pc = t; m_retire = 1'b1; m_instret = m_instret + 64'd1;
      end
`else
      m_pc = t - (t % 4); m_retire = 1'b1; m_instret = m_instret + 64'd1;
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc",        {32'h0, bus.o_pc},         {32'h0, m_pc});
      chk("imem_raddr",{32'h0, bus.o_imem_raddr}, {32'h0, m_pc});
      chk("pc_plus4",  {32'h0, bus.o_pc_plus4},   {32'h0, m_pc + 32'd4});
      chk("retire",    {63'h0, bus.o_retire},     {63'h0, m_retire});
      chk("instret",   bus.o_instret,             m_instret);
      chk("trap",      {63'h0, bus.o_trap},       {63'h0, m_trap});
      chk("trap_addr", {32'h0, bus.o_trap_addr},  {32'h0, m_trap_addr});
      chk("halt_state",{63'h0, (dbg_state == HALT)}, {63'h0, m_halt});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic br, input logic tk, input logic jal,
                       input logic jalr, input logic stall,
                       input logic [31:0] imm, input logic [31:0] rs1);
    bus.i_branch       = br;
    bus.i_branch_taken = tk;
    bus.i_jal          = jal;
    bus.i_jalr         = jalr;
    bus.i_stall        = stall;
    bus.i_immediate    = imm;
    bus.i_rs1_rdata    = rs1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    rst = 1'b1;
    step(2);
    chk("rst_pc",      {32'h0, bus.o_pc},       64'h0);
    chk("rst_plus4",   {32'h0, bus.o_pc_plus4}, 64'h4);
    chk("rst_retire",  {63'h0, bus.o_retire},   64'h0);
    chk("rst_instret", bus.o_instret,           64'h0);
    chk("rst_trap",    {63'h0, bus.o_trap},     64'h0);
    rst = 1'b0;

    // sequential fetch 0,4,8,C
    step(3);
    chk("seq_pc",      {32'h0, bus.o_pc}, 64'hC);
    chk("seq_instret", bus.o_instret,     64'd3);
    chk("seq_retire",  {63'h0, bus.o_retire}, 64'h1);

    // taken branch backwards from 0x10
    step(1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    step(1);
    chk("br_taken_pc", {32'h0, bus.o_pc}, 64'h8);
    idle();
    step(2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    step(1);
    chk("br_not_taken_pc", {32'h0, bus.o_pc}, 64'h14);

    // stall at 0x20 with a pending JAL
    idle();
    step(3);
    chk("at_20", {32'h0, bus.o_pc}, 64'h20);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    step(2);
    chk("stall_pc",     {32'h0, bus.o_pc},     64'h20);
    chk("stall_retire", {63'h0, bus.o_retire}, 64'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    step(1);
    chk("jal_pc",      {32'h0, bus.o_pc}, 64'h120);
    chk("jal_instret", bus.o_instret,     64'd12);

    // jump to the top of memory, then wrap to 0
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FEDC, 32'h0);
    step(1);
    chk("top_pc", {32'h0, bus.o_pc}, 64'hFFFF_FFFC);
    idle();
    step(1);
    chk("wrap_pc", {32'h0, bus.o_pc}, 64'h0);

    // counter wrap
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    step(1);
    chk("instret_wrap", bus.o_instret, 64'h0);
    chk("wrap_next_pc", {32'h0, bus.o_pc}, 64'h4);

    // misaligned JALR: 0x1001 + 2 = 0x1003 -> 0x1002
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2, 32'h1001);
    step(1);
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap_set",  {63'h0, bus.o_trap},      64'h1);
    chk("trap_addr", {32'h0, bus.o_trap_addr}, 64'h1002);
    chk("trap_pc",   {32'h0, bus.o_pc},        64'h4);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    step(2);
    chk("halt_pc",      {32'h0, bus.o_pc},     64'h4);
    chk("halt_instret", bus.o_instret,         64'd0);
    chk("halt_retire",  {63'h0, bus.o_retire}, 64'h0);
`else
    chk("jalr_forced_pc", {32'h0, bus.o_pc}, 64'h1000);
    chk("no_trap",        {63'h0, bus.o_trap}, 64'h0);
`endif

    // reset out of whatever state we are in
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    idle();
    chk("rerst_pc",      {32'h0, bus.o_pc},   64'h0);
    chk("rerst_trap",    {63'h0, bus.o_trap}, 64'h0);
    chk("rerst_instret", bus.o_instret,       64'h0);
    step(1);
    chk("resume_pc", {32'h0, bus.o_pc}, 64'h4);

    // priority: jalr beats jal and taken branch
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h200);
    step(1);
    chk("prio_jalr", {32'h0, bus.o_pc}, 64'h210);
    // jal beats branch with a different flag combination, stall mid-way
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    step(1);
    chk("prio_stall", {32'h0, bus.o_pc}, 64'h210);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    step(1);
    chk("prio_jal", {32'h0, bus.o_pc}, 64'h230);
    idle();
    step(2);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch-address stage of the single-cycle core. It holds the architectural PC and drives the instruction-memory read address. It consumes the sign-extended immediate from the immediate generator, plus branch/jump controls from the decoder, to form the next PC. It also detects misaligned control-transfer targets and counts retired instructions.

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- i_clk  in  1  core clock; all state updates on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_immediate  in  32  sign-extended immediate from the immediate generator.
- i_rs1_rdata  in  32  register-file rs1 value, used for JALR.
- i_branch  in  1  current instruction is B-type.
- i_branch_taken  in  1  branch comparator result; ignored unless i_branch.
- i_jal  in  1  current instruction is JAL.
- i_jalr  in  1  current instruction is JALR.
- i_stall  in  1  hold the PC this cycle; the instruction does not retire.
- o_imem_raddr  out  32  instruction-memory read address; equals o_pc.
- o_pc  out  32  current PC.
- o_pc_plus4  out  32  o_pc + 4, the link value for JAL/JALR rd.
- o_retire  out  1  one-cycle pulse, registered: the previous cycle's instruction retired.
- o_instret  out  64  retired-instruction count.
- o_trap  out  1  sticky misaligned-target trap flag.
- o_trap_addr  out  32  offending target address captured at trap.

## Operation
- State machine, two states:
  - RUN: the normal state.
  - HALT: entered only on a trap; left only by i_rst.
- Target computation, all 32-bit with wrap-around and carries beyond bit 31 discarded:
  - Branch/JAL target = o_pc + i_immediate.
  - JALR target = (i_rs1_rdata + i_immediate) with bit 0 cleared.
  - Sequential target = o_pc + 4.
- Next-PC priority, so behaviour is defined if the decoder asserts more than one control: i_jalr > i_jal > (i_branch & i_branch_taken) > sequential.
- RUN with !i_stall:
  - If the selected target is aligned (bits [1:0] == 0), PC loads the target, o_retire pulses next cycle, and o_instret increments.
  - If the selected non-sequential target is misaligned, the PC holds and state goes to HALT. o_trap sets, o_trap_addr captures the target, and the instruction does not retire.
- RUN with i_stall: PC, counter and trap state hold; o_retire is 0 next cycle.
- HALT:
  - PC, o_instret and o_trap_addr hold.
  - o_trap stays 1 and o_retire stays 0.
  - All control inputs and i_stall are ignored.
- o_instret wraps from 2^64-1 to 0 with no flag.
- Reset values:
  - o_pc = o_imem_raddr = RESET_ADDR
  - o_pc_plus4 = RESET_ADDR + 4
  - o_retire = 0
  - o_instret = 0
  - o_trap = 0
  - o_trap_addr = 0
  - state = RUN

## Timing
- The PC register updates on the rising edge after the controls are sampled. Next-PC logic is combinational from o_pc, i_immediate, i_rs1_rdata and the controls.
- o_imem_raddr and o_pc_plus4 are combinational from the PC register, so they are valid in the same cycle the PC register updates.
- o_retire and o_instret lag the PC update by zero cycles in register terms: they are written on the same edge as the PC, so o_retire is high during the cycle after the retiring instruction.
- i_rst has priority over every other input, including in HALT and mid-stall. The first post-reset fetch address is RESET_ADDR in the cycle after i_rst deasserts.
- Trap entry takes one cycle: o_trap is high on the edge following the offending instruction.

## Configuration
- PC_MISALIGN_TRAP_EN defined: misaligned-target detection and the HALT state behave as described above.
- PC_MISALIGN_TRAP_EN undefined:
  - Target bits [1:0] are forced to 00 before the PC loads.
  - HALT is unreachable, and o_trap and o_trap_addr are tied to 0.
  - Every non-stalled cycle retires.

## Structure
- Shared package pc_pkg holds:
  - the state enum (RUN, HALT);
  - the next-PC select encoding (SEQ, BRANCH, JAL, JALR);
  - the constant PC_INC = 4.
- One sub-module, pc_target: purely combinational. It takes o_pc, i_immediate, i_rs1_rdata and the controls, and returns the selected target and select code.
- pc_fetch contains the PC register, the FSM, the counter and the trap capture.

## Test plan
- Reset, then 3 unstalled cycles with no controls → o_pc sequence 0x0, 0x4, 0x8, 0xC; o_instret = 3; o_retire high on the last 3 cycles.
- At PC 0x10, i_branch=1, i_branch_taken=1, i_immediate=0xFFFF_FFF8 → next o_pc = 0x8. Same stimulus with i_branch_taken=0 → next o_pc = 0x14.
- i_jalr=1, i_rs1_rdata=0x1001, i_immediate=0x2 → target 0x1003 becomes 0x1002, which is misaligned. With the macro: o_trap=1, o_trap_addr=0x1002, PC holds, and o_instret is unchanged in later cycles. Without the macro: o_pc = 0x1000.
- i_stall=1 for 2 cycles at PC 0x20 with i_jal=1 → PC stays 0x20 and o_retire=0. Release the stall with i_immediate=0x100 → o_pc = 0x120.
- In HALT, assert i_rst for one cycle → o_pc = RESET_ADDR, o_trap = 0, o_instret = 0, and normal sequential fetch resumes.
- At PC 0xFFFF_FFFC with no controls → o_pc wraps to 0x0. Preload o_instret to 2^64-1 by force, then retire one instruction → o_instret = 0.
